// File: rtl/fpu_pkg.sv
// Shared FPU result-buffer definitions: word layout, status codes,
// capture FSM states and result classes.
package fpu_pkg;

  localparam int EXP_W    = 10;
  localparam int MANT_W   = 21;
  localparam int EXP_BIAS = 511;

  localparam logic [EXP_W-1:0] EXP_MAX = 10'h3FF;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
  } fpu_word_t;

  typedef enum logic [3:0] {
    BUSY      = 4'b0000,
    EXACT     = 4'b0001,
    OVERFLOW  = 4'b0010,
    UNDERFLOW = 4'b0100,
    INEXACT   = 4'b1000
  } status_t;

  typedef enum logic [1:0] {
    ARMED,
    SETTLING,
    HOLD
  } cap_state_t;

  typedef enum logic [2:0] {
    CLS_ZERO       = 3'b000,
    CLS_INF        = 3'b001,
    CLS_NAN        = 3'b010,
    CLS_NORMAL     = 3'b011,
    CLS_NEG_ZERO   = 3'b100,
    CLS_NEG_INF    = 3'b101,
    CLS_NEG_NORMAL = 3'b111
  } class_t;

  // A status carries a result only when exactly one flag is set.
  function automatic logic status_is_result(
    input logic [3:0] s
  );
    return $onehot(s);
  endfunction

endpackage

// File: rtl/fpu_result_classifier.sv
// Combinational classifier for a popped FPU word.
// Ports: word_i (fpu_word_t) -> class_o (ZERO/INF/NAN/NORMAL, +100 if negative, not for NAN).
module fpu_result_classifier
  import fpu_pkg::*;
(
  input  fpu_word_t word_i,
  output class_t    class_o
);

  logic [2:0] base;

  always_comb begin
    base = CLS_NORMAL;
    if (word_i.exp == '0) begin
      base = CLS_ZERO;
    end else if (word_i.exp == EXP_MAX) begin
      if (word_i.mant == '0) begin
        base = CLS_INF;
      end else begin
        base = CLS_NAN;
      end
    end
  end

  always_comb begin
    if (word_i.sign && (base != CLS_NAN)) begin
      class_o = class_t'(base | 3'b100);
    end else begin
      class_o = class_t'(base);
    end
  end

endmodule

// File: rtl/fpu_result_buffer.sv
// Captures one settled {status,result} per FPU operation into a FIFO drained by a pop handshake.
// Ports: clock_100KHz, reset (sync, high); fpu_data_in[31:0], fpu_status_in[3:0]; rd_en;
// rd_data/rd_status/rd_valid (registered); empty, full, count, drop_cnt, proto_err.
// Build option RESULT_CLASSIFY_EN adds rd_class[2:0], registered with rd_data.
module fpu_result_buffer
  import fpu_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int SETTLE = 2
) (
  input  logic                     clock_100KHz,
  input  logic                     reset,
  input  logic [31:0]              fpu_data_in,
  input  logic [3:0]               fpu_status_in,
  input  logic                     rd_en,
  output logic [31:0]              rd_data,
  output logic [3:0]               rd_status,
  output logic                     rd_valid,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic [7:0]               drop_cnt,
  output logic                     proto_err
`ifdef RESULT_CLASSIFY_EN
  ,
  output logic [2:0]               rd_class
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int SW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);

  // ---------------- capture FSM ----------------
  cap_state_t  state_q, state_d;
  logic [31:0] snap_data_q, snap_data_d;
  logic [3:0]  snap_stat_q, snap_stat_d;
  logic [SW-1:0] stab_q, stab_d;
  logic [SW-1:0] stab_inc;

  logic in_zero;
  logic in_valid;
  logic in_match;
  logic push_req;
  logic proto_set;

  assign in_zero  = (fpu_status_in == BUSY);
  assign in_valid = status_is_result(fpu_status_in);
  assign in_match = (fpu_data_in == snap_data_q) &&
                    (fpu_status_in == snap_stat_q);
  assign stab_inc = stab_q + 1'b1;

  always_ff @(posedge clock_100KHz) begin
    if (reset) begin
      state_q     <= ARMED;
      snap_data_q <= '0;
      snap_stat_q <= '0;
      stab_q      <= '0;
    end else begin
      state_q     <= state_d;
      snap_data_q <= snap_data_d;
      snap_stat_q <= snap_stat_d;
      stab_q      <= stab_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    snap_data_d = snap_data_q;
    snap_stat_d = snap_stat_q;
    stab_d      = stab_q;
    unique case (state_q)
      ARMED: begin
        if (in_valid) begin
          snap_data_d = fpu_data_in;
          snap_stat_d = fpu_status_in;
          stab_d      = SW'(1);
          // With SETTLE=1 the first valid cycle is already settled.
          state_d     = (SETTLE <= 1) ? HOLD : SETTLING;
        end
      end
      SETTLING: begin
        if (in_match) begin
          stab_d = stab_inc;
          if (stab_inc == SW'(SETTLE)) begin
            state_d = HOLD;
          end
        end else if (in_valid) begin
          snap_data_d = fpu_data_in;
          snap_stat_d = fpu_status_in;
          stab_d      = SW'(1);
        end else begin
          state_d = ARMED;
        end
      end
      HOLD: begin
        if (in_zero) begin
          state_d = ARMED;
        end
      end
      default: state_d = ARMED;
    endcase
  end

  always_comb begin
    push_req  = 1'b0;
    proto_set = 1'b0;
    unique case (state_q)
      ARMED: begin
        push_req  = in_valid && (SETTLE <= 1);
        proto_set = !in_zero && !in_valid;
      end
      SETTLING: begin
        push_req  = in_match && (stab_inc == SW'(SETTLE));
        proto_set = !in_match && !in_zero && !in_valid;
      end
      default: begin
        push_req  = 1'b0;
        proto_set = 1'b0;
      end
    endcase
  end

  // ---------------- FIFO ----------------
  logic [31:0]   data_mem [DEPTH];
  logic [3:0]    stat_mem [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW-1:0] wr_ptr_d, rd_ptr_d;
  logic [AW-1:0] wr_idx, rd_idx;
  logic          empty_q, full_q;
  logic [31:0]   rd_data_q;
  logic [3:0]    rd_status_q;
  logic          rd_valid_q;
  logic [7:0]    drop_q;
  logic          proto_q;
  logic          do_pop, do_push, do_drop;

  assign wr_idx = wr_ptr_q[AW-1:0];
  assign rd_idx = rd_ptr_q[AW-1:0];

  // A pop on a full FIFO frees the slot the same-cycle push needs.
  assign do_pop  = rd_en && !empty_q;
  assign do_push = push_req && (!full_q || do_pop);
  assign do_drop = push_req && full_q && !do_pop;

  assign wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
  assign rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

  always_ff @(posedge clock_100KHz) begin
    if (do_push && !reset) begin
      data_mem[wr_idx] <= fpu_data_in;
      stat_mem[wr_idx] <= fpu_status_in;
    end
  end

  always_ff @(posedge clock_100KHz) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      rd_data_q   <= '0;
      rd_status_q <= '0;
      rd_valid_q  <= 1'b0;
      drop_q      <= '0;
      proto_q     <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      empty_q    <= (wr_ptr_d == rd_ptr_d);
      full_q     <= (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                    (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
      rd_valid_q <= do_pop;
      if (do_pop) begin
        rd_data_q   <= data_mem[rd_idx];
        rd_status_q <= stat_mem[rd_idx];
      end
      if (do_drop && (drop_q != 8'hFF)) begin
        drop_q <= drop_q + 8'd1;
      end
      if (proto_set) begin
        proto_q <= 1'b1;
      end
    end
  end

`ifdef RESULT_CLASSIFY_EN
  class_t     head_class;
  logic [2:0] rd_class_q;

  fpu_result_classifier u_classifier (
    .word_i  (fpu_word_t'(data_mem[rd_idx])),
    .class_o (head_class)
  );

  always_ff @(posedge clock_100KHz) begin
    if (reset) begin
      rd_class_q <= '0;
    end else if (do_pop) begin
      rd_class_q <= head_class;
    end
  end

  assign rd_class = rd_class_q;
`endif

  assign rd_data   = rd_data_q;
  assign rd_status = rd_status_q;
  assign rd_valid  = rd_valid_q;
  assign empty     = empty_q;
  assign full      = full_q;
  assign count     = wr_ptr_q - rd_ptr_q;
  assign drop_cnt  = drop_q;
  assign proto_err = proto_q;

endmodule

// File: tb/tb_fpu_result_buffer.sv
// Directed + randomized bench for fpu_result_buffer against a queue-based reference model.
// Build with RESULT_CLASSIFY_EN to also check rd_class.
module tb_fpu_result_buffer;

  localparam int DEPTH  = 4;
  localparam int SETTLE = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] din = '0;
  logic [3:0]  sin = '0;
  logic        rd_en = 1'b0;
  logic [31:0] rd_data;
  logic [3:0]  rd_status;
  logic        rd_valid;
  logic        empty;
  logic        full;
  logic [2:0]  count;
  logic [7:0]  drop_cnt;
  logic        proto_err;
`ifdef RESULT_CLASSIFY_EN
  logic [2:0]  rd_class;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fpu_result_buffer #(
    .DEPTH  (DEPTH),
    .SETTLE (SETTLE)
  ) dut (
    .clock_100KHz  (clk),
    .reset         (reset),
    .fpu_data_in   (din),
    .fpu_status_in (sin),
    .rd_en         (rd_en),
    .rd_data       (rd_data),
    .rd_status     (rd_status),
    .rd_valid      (rd_valid),
    .empty         (empty),
    .full          (full),
    .count         (count),
    .drop_cnt      (drop_cnt),
    .proto_err     (proto_err)
`ifdef RESULT_CLASSIFY_EN
    ,
    .rd_class      (rd_class)
`endif
  );

  // Reference model: a queue of captured entries plus the run length
  // of identical valid {data,status} cycles within the current operation.
  logic [35:0] q[$];
  int          run;
  logic [35:0] prev;
  bit          captured;
  bit          m_proto;
  int          m_drop;
  logic        m_valid;
  logic [31:0] m_data;
  logic [3:0]  m_stat;

  task automatic chk(input string tag,
                     input logic [35:0] obs,
                     input logic [35:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic model_clear();
    q.delete();
    run      = 0;
    prev     = '0;
    captured = 0;
    m_proto  = 0;
    m_drop   = 0;
    m_valid  = 0;
    m_data   = '0;
    m_stat   = '0;
  endtask

  task automatic model_tick(input logic [31:0] d,
                            input logic [3:0] s,
                            input logic r);
    bit pop_ok;
    bit cap;
    logic [35:0] e;
    pop_ok = r && (q.size() > 0);
    cap = 0;
    if (captured) begin
      if (s == 4'd0) captured = 0;
    end else if (s == 4'd0) begin
      run = 0;
    end else if (!$onehot(s)) begin
      m_proto = 1;
      run = 0;
    end else begin
      if (run > 0 && {s, d} == prev) run++;
      else run = 1;
      prev = {s, d};
      if (run >= SETTLE) begin
        cap = 1;
        captured = 1;
        run = 0;
      end
    end
    m_valid = pop_ok;
    if (pop_ok) begin
      e = q.pop_front();
      m_stat = e[35:32];
      m_data = e[31:0];
    end
    if (cap) begin
      if (q.size() < DEPTH) q.push_back({s, d});
      else if (m_drop < 255) m_drop++;
    end
  endtask

  task automatic check_all();
    chk("count", 36'(count), 36'(q.size()));
    chk("empty", 36'(empty), 36'(q.size() == 0));
    chk("full", 36'(full), 36'(q.size() == DEPTH));
    chk("drop_cnt", 36'(drop_cnt), 36'(m_drop));
    chk("proto_err", 36'(proto_err), 36'(m_proto));
    chk("rd_valid", 36'(rd_valid), 36'(m_valid));
    chk("rd_data", 36'(rd_data), 36'(m_data));
    chk("rd_status", 36'(rd_status), 36'(m_stat));
  endtask

  task automatic step(input logic [31:0] d,
                      input logic [3:0] s,
                      input logic r,
                      input logic rst = 1'b0);
    @(negedge clk);
    din = d;
    sin = s;
    rd_en = r;
    reset = rst;
    @(posedge clk);
    if (rst) model_clear();
    else model_tick(d, s, r);
    #1;
    check_all();
  endtask

  task automatic op(input logic [31:0] d,
                    input logic [3:0] s,
                    input int hold);
    for (int i = 0; i < hold; i++) step(d, s, 1'b0);
    step(32'd0, 4'd0, 1'b0);
  endtask

  initial begin
    logic [31:0] rd;
    logic [3:0]  rs;
    int          hl;
    int          pick;

    model_clear();
    step(32'd0, 4'd0, 1'b0, 1'b1);
    step(32'd0, 4'd0, 1'b1, 1'b1);
    chk("reset_empty", 36'(empty), 36'd1);
    chk("reset_valid", 36'(rd_valid), 36'd0);
    step(32'd0, 4'd0, 1'b1);
    chk("pop_when_empty", 36'(rd_valid), 36'd0);

    // single result
    step(32'h2014_0000, 4'b0001, 1'b0);
    chk("single_cnt_c1", 36'(count), 36'd0);
    step(32'h2014_0000, 4'b0001, 1'b0);
    chk("single_cnt_c2", 36'(count), 36'd1);
    for (int i = 0; i < 3; i++) step(32'h2014_0000, 4'b0001, 1'b0);
    chk("single_once", 36'(count), 36'd1);
    step(32'd0, 4'd0, 1'b0);
    step(32'd0, 4'd0, 1'b1);
    chk("single_valid", 36'(rd_valid), 36'd1);
    chk("single_data", 36'(rd_data), 36'h0_2014_0000);
    chk("single_stat", 36'(rd_status), 36'd1);
    step(32'd0, 4'd0, 1'b0);
    chk("hold_data", 36'(rd_data), 36'h0_2014_0000);

    // glitch
    step(32'h20AA_AAAA, 4'b1000, 1'b0);
    for (int i = 0; i < 4; i++) step(32'h201F_FFFF, 4'b1000, 1'b0);
    step(32'd0, 4'd0, 1'b0);
    chk("glitch_cnt", 36'(count), 36'd1);
    step(32'd0, 4'd0, 1'b1);
    chk("glitch_data", 36'(rd_data), 36'h0_201F_FFFF);
    step(32'd0, 4'd0, 1'b0);
    chk("glitch_empty", 36'(empty), 36'd1);

    // fill and drop
    for (int i = 0; i < 5; i++) begin
      op(32'h3000_0000 + i, 4'b0010, 3);
      if (i == 3) begin
        chk("fill_full", 36'(full), 36'd1);
        chk("fill_cnt", 36'(count), 36'd4);
      end
    end
    chk("fill_drop", 36'(drop_cnt), 36'd1);

    // simultaneous push+pop while full
    step(32'd0, 4'd0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) op(32'h3100_0000 + i, 4'b0010, 2);
    step(32'h3100_0004, 4'b0010, 1'b0);
    step(32'h3100_0004, 4'b0010, 1'b1);
    chk("simul_drop", 36'(drop_cnt), 36'd0);
    chk("simul_cnt", 36'(count), 36'd4);
    chk("simul_data", 36'(rd_data), 36'h0_3100_0000);
    step(32'd0, 4'd0, 1'b0);
    for (int i = 0; i < 5; i++) step(32'd0, 4'd0, 1'b1);
    chk("drain_last", 36'(rd_data), 36'h0_3100_0004);

    // invalid status
    step(32'h0000_0055, 4'b0011, 1'b0);
    chk("proto_set", 36'(proto_err), 36'd1);
    step(32'd0, 4'd0, 1'b0);
    chk("proto_sticky", 36'(proto_err), 36'd1);
    chk("proto_noentry", 36'(count), 36'd0);
    step(32'd0, 4'd0, 1'b0, 1'b1);
    chk("proto_clear", 36'(proto_err), 36'd0);

    // reset mid-settling and mid-pop
    step(32'h2014_0000, 4'b0001, 1'b0);
    step(32'h2014_0000, 4'b0001, 1'b0, 1'b1);
    step(32'h2014_0000, 4'b0001, 1'b0);
    chk("rst_settle_c1", 36'(count), 36'd0);
    step(32'h2014_0000, 4'b0001, 1'b0);
    chk("rst_settle_c2", 36'(count), 36'd1);
    step(32'd0, 4'd0, 1'b1, 1'b1);
    chk("rst_pop_valid", 36'(rd_valid), 36'd0);
    step(32'd0, 4'd0, 1'b0);

    // randomized operations
    for (int n = 0; n < 250; n++) begin
      pick = int'($urandom_range(0, 39));
      if (pick < 8) rs = 4'd0;
      else if (pick == 39) rs = 4'b0110;
      else rs = 4'(1 << $urandom_range(0, 3));
      rd = 32'h2014_0000 + $urandom_range(0, 2);
      hl = int'($urandom_range(1, 4));
      for (int k = 0; k < hl; k++) begin
        step(rd, rs, 1'($urandom_range(0, 2) == 0));
      end
    end

`ifdef RESULT_CLASSIFY_EN
    step(32'd0, 4'd0, 1'b0, 1'b1);
    op(32'h7FE0_0000, 4'b0001, 2);
    op(32'hFFE0_0001, 4'b0100, 2);
    op(32'h0000_0000, 4'b0001, 2);
    step(32'd0, 4'd0, 1'b1);
    chk("class_inf", 36'(rd_class), 36'b001);
    step(32'd0, 4'd0, 1'b1);
    chk("class_nan", 36'(rd_class), 36'b010);
    step(32'd0, 4'd0, 1'b1);
    chk("class_zero", 36'(rd_class), 36'b000);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
